lsu_bus_master: RTL
===================

# lsu_bus_master

CPU-side initiator for the word-addressed peripheral data bus. Accepts one load/store request at a time from the CPU pipeline over a valid/ready handshake, checks it against the RAM address window, and drives the bus (`bus_addr`, `bus_w_r`, `bus_wr_data`) for the required number of cycles. For loads it samples `bus_rd_data`; every request gets a response on a second valid/ready handshake, including an error flag for unmapped addresses.

## Interface
Parameters:
- `RAM_BASE`, 32'h0000_0000, first word address mapped to RAM
- `RAM_LAST`, 32'h0000_0063, last word address mapped to RAM (inclusive)
- `BUS_LAT`, 1, cycles the bus is driven before read data is sampled or the write is retired (≥1)
- `IDLE_ADDR`, 32'hFFFF_FFFF, address driven while idle (must lie outside every mapped window)

Ports:
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1: request present
- `req_ready` out 1: block can accept a request
- `req_we` in 1: 1 = store, 0 = load
- `req_addr` in 32: word address
- `req_wdata` in 32: store data
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: pipeline accepts response
- `rsp_rdata` out 32: load data (0 for stores and errors)
- `rsp_err` out 1: address outside `[RAM_BASE, RAM_LAST]`
- `bus_addr` out 32: bus address
- `bus_w_r` out 1: 1 = write, 0 = read
- `bus_wr_data` out 32: bus write data
- `bus_rd_data` in 32: bus read data, valid by the rising edge after the slave's falling-edge response

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch `req_we/addr/wdata`. In-range → ACCESS, load wait counter with `BUS_LAT`-1. Out-of-range → RESP with `rsp_err`=1, `rsp_rdata`=0, no bus activity.
- ACCESS: drive `bus_addr`=latched addr, `bus_w_r`=latched we, `bus_wr_data`=latched wdata (0 for loads). Counter decrements each cycle; at 0 → RESP. For loads `rsp_rdata` ← `bus_rd_data` on that same edge.
- RESP: `rsp_valid`=1, `rsp_rdata`/`rsp_err` held stable until `rsp_valid && rsp_ready`, then → IDLE.
- Outside ACCESS: `bus_addr`=`IDLE_ADDR`, `bus_w_r`=0, `bus_wr_data`=0; no bus transaction occurs.
- Range check is inclusive at both ends; comparison unsigned 32-bit.
- Counter width = $clog2(`BUS_LAT`+1); never wraps.

## Timing
- Reset values: `req_ready`=0 during reset cycle, 1 from first post-reset cycle; `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `bus_addr`=`IDLE_ADDR`, `bus_w_r`=0, `bus_wr_data`=0; state IDLE.
- All outputs registered; no combinational path from any input to any output.
- In-range request accepted at edge T: bus driven from T+1 for exactly `BUS_LAT` cycles; `rsp_valid` rises at T+1+`BUS_LAT` (T+2 at default).
- Unmapped request accepted at T: `rsp_valid` at T+1.
- Response handshake at edge R: `req_ready`=1 from R+1; back-to-back in-range throughput = one request per `BUS_LAT`+2 cycles when `rsp_ready` held high.
- `rsp_ready` low: response stalls indefinitely; bus stays idle; no new request accepted.
- `req_valid` while not ready: ignored, no latching.
- `rst` asserted in any state: next edge returns to reset values; in-flight bus cycle abandoned, pending response discarded.

## Structure
- Shared package `bus_pkg`: `RAM_BASE`, `RAM_LAST`, `IDLE_ADDR` constants; `BUS_WRITE`=1'b1 / `BUS_READ`=1'b0 encodings; state enum.
- One sub-module: `bus_addr_decode` (combinational, in-range flag from address and window parameters), reused later by the GPIO initiator.

## Test plan
- Reset: assert `rst` 2 cycles → all outputs at reset values, `bus_addr`=32'hFFFF_FFFF, `bus_w_r`=0.
- Store addr 0x10 data 0xDEADBEEF, then load 0x10 against a RAM model → bus shows `w_r`=1 for 1 cycle; load `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` 2 cycles after accept.
- Boundaries: load 0x63 → err=0, bus cycle issued; load 0x64 and 0xFFFF_FFF0 → `rsp_err`=1, `rsp_rdata`=0, `rsp_valid` 1 cycle after accept, `bus_addr` stays 0xFFFF_FFFF.
- Backpressure: `rsp_ready`=0 for 5 cycles after load 0x05 → `rsp_valid` and data stable, `req_ready`=0, second request not accepted until handshake.
- `BUS_LAT`=3 build: store 0x20 → `bus_w_r`=1 for exactly 3 cycles; `rsp_valid` 4 cycles after accept.
- Reset mid-ACCESS on a store → bus returns to idle next edge, no `rsp_valid`, `req_ready`=1 after release.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants, bus encodings and FSM state type for the peripheral-bus initiators.
// No logic; imported by the LSU bus master and the address decoder.
package bus_pkg;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] RAM_LAST  = 32'h0000_0063;
    localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF;

    localparam logic BUS_WRITE = 1'b1;
    localparam logic BUS_READ  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational window check: flags addresses inside [BASE, LAST], inclusive, unsigned.
// One subtract-and-compare keeps the check valid for any BASE, including zero.
module bus_addr_decode #(
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter logic [31:0] LAST = 32'h0000_0063
) (
    input  logic [31:0] i_addr,
    output logic        o_in_range
);

    localparam logic [31:0] SPAN = LAST - BASE;

    logic [31:0] w_offset;

    assign w_offset   = i_addr - BASE;
    assign o_in_range = (w_offset <= SPAN);

endmodule

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store initiator: bus driven BUS_LAT cycles, response one cycle later.
// Response holds until accepted; no new request is taken while a response is pending.
module lsu_bus_master
    import bus_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = bus_pkg::RAM_BASE,
    parameter logic [31:0] RAM_LAST  = bus_pkg::RAM_LAST,
    parameter int          BUS_LAT   = 1,
    parameter logic [31:0] IDLE_ADDR = bus_pkg::IDLE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] bus_addr,
    output logic        bus_w_r,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data
);

    localparam int              CW     = $clog2(BUS_LAT + 1);
    localparam logic [CW-1:0]   LAT_M1 = CW'(BUS_LAT - 1);

    lsu_state_t    r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_we, w_we;
    logic          r_req_ready, w_req_ready;
    logic          r_rsp_valid, w_rsp_valid;
    logic [31:0]   r_rsp_rdata, w_rsp_rdata;
    logic          r_rsp_err, w_rsp_err;
    logic [31:0]   r_bus_addr, w_bus_addr;
    logic          r_bus_w_r, w_bus_w_r;
    logic [31:0]   r_bus_wr_data, w_bus_wr_data;
    logic          w_in_range;

    bus_addr_decode #(
        .BASE (RAM_BASE),
        .LAST (RAM_LAST)
    ) u_decode (
        .i_addr     (req_addr),
        .o_in_range (w_in_range)
    );

    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_we          = r_we;
        w_req_ready   = r_req_ready;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
        w_bus_addr    = r_bus_addr;
        w_bus_w_r     = r_bus_w_r;
        w_bus_wr_data = r_bus_wr_data;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_req_ready = 1'b0;
                    w_we        = req_we;
                    if (w_in_range) begin
                        w_state       = ST_ACCESS;
                        w_cnt         = LAT_M1;
                        w_bus_addr    = req_addr;
                        w_bus_w_r     = req_we;
                        w_bus_wr_data = req_we ? req_wdata : 32'd0;
                    end else begin
                        // Unmapped: answer immediately without touching the bus.
                        w_state     = ST_RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                        w_rsp_rdata = 32'd0;
                    end
                end
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state       = ST_RESP;
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = 1'b0;
                    w_rsp_rdata   = (r_we == BUS_WRITE) ? 32'd0 : bus_rd_data;
                    w_bus_addr    = IDLE_ADDR;
                    w_bus_w_r     = BUS_READ;
                    w_bus_wr_data = 32'd0;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state     = ST_IDLE;
                    w_rsp_valid = 1'b0;
                    w_rsp_rdata = 32'd0;
                    w_rsp_err   = 1'b0;
                    w_req_ready = 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_err     <= 1'b0;
            r_bus_addr    <= IDLE_ADDR;
            r_bus_w_r     <= BUS_READ;
            r_bus_wr_data <= 32'd0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_we          <= w_we;
            r_req_ready   <= w_req_ready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
            r_bus_addr    <= w_bus_addr;
            r_bus_w_r     <= w_bus_w_r;
            r_bus_wr_data <= w_bus_wr_data;
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign bus_addr    = r_bus_addr;
    assign bus_w_r     = r_bus_w_r;
    assign bus_wr_data = r_bus_wr_data;

endmodule
